// File: rtl/order_dispatcher.sv
// Order dispatcher: gates buy/sell requests against per-stock position limits, queues
// accepted orders and serialises them as header/payload bytes. Define ORDER_CHECKSUM_EN
// to append a header-XOR-payload checksum byte to every order.
module order_dispatcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_POS    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       buy_signal,
   input  logic       sell_signal,
   input  logic [1:0] stock_id,
   input  logic [5:0] price,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [1:0] pos_sel,
   output logic [3:0] pos_out,
   output logic [7:0] drop_cnt,
   output logic       busy
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  MAX_POS_V = 4'(MAX_POS);

`ifdef ORDER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

   // Queue entry layout: {side, stock_id[1:0], price[5:0]}, side 0 = buy, 1 = sell.
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    pos [4];

   state_t     state_q, state_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [8:0] cur_q, cur_d;
   logic [2:0] seq_q, seq_d;

   logic full, empty, pop, buy_ok, sell_ok, push, drop;

   function automatic logic [7:0] hdr_byte(input logic [8:0] e, input logic [2:0] s);
      return {2'b10, e[8], e[7:6], s};
   endfunction

   // Fullness comes from the registered count, so a same-cycle pop never frees room.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop     = (state_q == IDLE) && !empty;
   assign buy_ok  = buy_signal && !sell_signal && (pos[stock_id] < MAX_POS_V) && !full;
   assign sell_ok = sell_signal && !buy_signal && (pos[stock_id] != 4'd0) && !full;
   assign push    = buy_ok || sell_ok;
   assign drop    = (buy_signal || sell_signal) && !push;

   assign pos_out  = pos[pos_sel];
   assign tx_data  = tx_data_q;
   assign tx_valid = (state_q != IDLE);
   assign busy     = !empty || (state_q != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the queue storage is small enough to clear on reset as well.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         for (int i = 0; i < 4; i++) pos[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         drop_cnt  <= '0;
         state_q   <= IDLE;
         tx_data_q <= '0;
         cur_q     <= '0;
         seq_q     <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {sell_ok, stock_id, price};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Positions move at acceptance so queued orders already count against limits.
         if (buy_ok)       pos[stock_id] <= pos[stock_id] + 1'b1;
         else if (sell_ok) pos[stock_id] <= pos[stock_id] - 1'b1;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         cur_q     <= cur_d;
         seq_q     <= seq_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      cur_d     = cur_q;
      seq_d     = seq_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               cur_d     = mem[rd_ptr];
               tx_data_d = hdr_byte(mem[rd_ptr], seq_q);
               state_d   = HDR;
            end
         end
         HDR: begin
            if (tx_ready) begin
               tx_data_d = {2'b00, cur_q[5:0]};
               state_d   = PAY;
            end
         end
         PAY: begin
            if (tx_ready) begin
`ifdef ORDER_CHECKSUM_EN
               tx_data_d = hdr_byte(cur_q, seq_q) ^ {2'b00, cur_q[5:0]};
               state_d   = CHK;
`else
               tx_data_d = 8'h00;
               seq_d     = seq_q + 3'd1;
               state_d   = IDLE;
`endif
            end
         end
`ifdef ORDER_CHECKSUM_EN
         CHK: begin
            if (tx_ready) begin
               tx_data_d = 8'h00;
               seq_d     = seq_q + 3'd1;
               state_d   = IDLE;
            end
         end
`endif
         default: begin
            tx_data_d = 8'h00;
            state_d   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_order_dispatcher.sv
// Directed self-checking bench for order_dispatcher; expected bytes are hand-computed.
// Honours ORDER_CHECKSUM_EN for the third order byte.
module tb_order_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       buy_signal, sell_signal;
   logic [1:0] stock_id;
   logic [5:0] price;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [1:0] pos_sel;
   logic [3:0] pos_out;
   logic [7:0] drop_cnt;
   logic       busy;

   int total = 0;
   int bad   = 0;

   order_dispatcher #(.FIFO_DEPTH(4), .MAX_POS(15)) dut (
      .clk(clk), .rst(rst), .buy_signal(buy_signal), .sell_signal(sell_signal),
      .stock_id(stock_id), .price(price), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .pos_sel(pos_sel), .pos_out(pos_out), .drop_cnt(drop_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      buy_signal = 1'b0; sell_signal = 1'b0; stock_id = 2'd0; price = 6'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic read_pos(input logic [1:0] sel, output logic [3:0] v);
      pos_sel = sel;
      #1;
      v = pos_out;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic request(input logic b, input logic s, input logic [1:0] id, input logic [5:0] p);
      buy_signal = b; sell_signal = s; stock_id = id; price = p;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      logic [3:0] v;
      // A request presented during reset must be ignored.
      buy_signal = 1'b1; stock_id = 2'd1; price = 6'd9; tx_ready = 1'b1;
      do_reset();
      idle_inputs();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      tick();
      for (int i = 0; i < 4; i++) begin
         read_pos(2'(i), v);
         total++; if (v !== 4'd0) begin bad++; $display("FAIL reset_pos%0d got %0d want 0", i, v); end
      end
   endtask

   task automatic test_basic();
      logic [3:0] v;
      bit ok;
      tx_ready = 1'b1;
      request(1'b1, 1'b0, 2'd1, 6'd20);
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_n1_valid got %b want 0", tx_valid); end
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h88) begin bad++; $display("FAIL basic_hdr got %b/%h want 1/88", tx_valid, tx_data); end
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h14) begin bad++; $display("FAIL basic_pay got %b/%h want 1/14", tx_valid, tx_data); end
`ifdef ORDER_CHECKSUM_EN
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h9C) begin bad++; $display("FAIL basic_chk got %b/%h want 1/9c", tx_valid, tx_data); end
`endif
      tick();
      total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL basic_gap got %b/%h want 0/00", tx_valid, tx_data); end
      read_pos(2'd1, v);
      total++; if (v !== 4'd1) begin bad++; $display("FAIL basic_pos1 got %0d want 1", v); end
      // Sell of stock 1 at seq 1: header {10,1,01,001} = A9.
      request(1'b0, 1'b1, 2'd1, 6'd5);
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA9) begin bad++; $display("FAIL sell_hdr got %b/%h want 1/a9", tx_valid, tx_data); end
      tick();
      total++; if (tx_data !== 8'h05) begin bad++; $display("FAIL sell_pay got %h want 05", tx_data); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL sell_drain got busy want idle"); end
      read_pos(2'd1, v);
      total++; if (v !== 4'd0) begin bad++; $display("FAIL sell_pos1 got %0d want 0", v); end
   endtask

   task automatic test_drops();
      logic [3:0] v;
      request(1'b0, 1'b1, 2'd2, 6'd7);
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL empty_sell_drop got %0d want 1", drop_cnt); end
      tick();
      total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_sell_tx got %b/%b want 0/0", tx_valid, busy); end
      request(1'b1, 1'b1, 2'd0, 6'd7);
      total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL conflict_drop got %0d want 2", drop_cnt); end
      read_pos(2'd0, v);
      total++; if (v !== 4'd0) begin bad++; $display("FAIL conflict_pos0 got %0d want 0", v); end
   endtask

   task automatic test_backpressure();
      logic [3:0] v;
      bit ok;
      tx_ready = 1'b0;
      do_reset();
      // Park an order in HDR so the queue cannot drain.
      request(1'b1, 1'b0, 2'd1, 6'd20);
      tick();
      for (int i = 0; i < 6; i++) begin
         buy_signal = 1'b1; stock_id = 2'd0; price = 6'(i + 1);
         tick();
         total++; if (tx_valid !== 1'b1 || tx_data !== 8'h88) begin bad++; $display("FAIL hold_stable[%0d] got %b/%h want 1/88", i, tx_valid, tx_data); end
      end
      idle_inputs();
      total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL full_drop got %0d want 2", drop_cnt); end
      read_pos(2'd0, v);
      total++; if (v !== 4'd4) begin bad++; $display("FAIL full_pos0 got %0d want 4", v); end
      // Release the parked order and reach IDLE with the queue still full.
      tx_ready = 1'b1;
      tick();
`ifdef ORDER_CHECKSUM_EN
      tick();
`endif
      tick();
      tx_ready = 1'b0;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL release_idle got %b want 0", tx_valid); end
      // Pop happens this cycle, but fullness is judged on the registered count.
      request(1'b1, 1'b0, 2'd0, 6'd1);
      total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL pop_same_cycle_drop got %0d want 3", drop_cnt); end
      total++; if (tx_data !== 8'h81) begin bad++; $display("FAIL queued_hdr got %h want 81", tx_data); end
      read_pos(2'd0, v);
      total++; if (v !== 4'd4) begin bad++; $display("FAIL pop_same_cycle_pos got %0d want 4", v); end
      tx_ready = 1'b1;
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL backpressure_drain got busy want idle"); end
   endtask

   task automatic test_seq_wrap();
      logic [3:0] v;
      logic [2:0] s;
      bit ok;
      tx_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         s = 3'(i);
         request(1'b1, 1'b0, 2'd3, 6'(i));
         tick();
         if (i < 15) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== {2'b10, 1'b0, 2'b11, s}) begin bad++; $display("FAIL wrap_hdr[%0d] got %b/%h want 1/%h", i, tx_valid, tx_data, {2'b10, 1'b0, 2'b11, s}); end
         end else begin
            total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wrap_limit_tx got %b want 0", tx_valid); end
         end
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL wrap_drain[%0d] got busy want idle", i); end
      end
      read_pos(2'd3, v);
      total++; if (v !== 4'd15) begin bad++; $display("FAIL wrap_pos3 got %0d want 15", v); end
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL wrap_drop got %0d want 1", drop_cnt); end
   endtask

   task automatic test_rst_in_pay();
      logic [3:0] v;
      tx_ready = 1'b1;
      do_reset();
      request(1'b1, 1'b0, 2'd2, 6'd3);
      tick();
      tick();
      tx_ready = 1'b0;
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h03) begin bad++; $display("FAIL pay_hold got %b/%h want 1/03", tx_valid, tx_data); end
      rst = 1'b1; buy_signal = 1'b1; stock_id = 2'd2;
      tick();
      rst = 1'b0;
      idle_inputs();
      total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rst_pay got %b/%b/%h want 0/0/00", tx_valid, busy, tx_data); end
      read_pos(2'd2, v);
      total++; if (v !== 4'd0) begin bad++; $display("FAIL rst_pay_pos2 got %0d want 0", v); end
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_pay_abandon got %b want 0", tx_valid); end
   endtask

   task automatic test_drop_saturate();
      do_reset();
      buy_signal = 1'b1; sell_signal = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      idle_inputs();
      total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1; tx_ready = 1'b0; pos_sel = 2'd0;
      #2;
      test_reset();
      test_basic();
      test_drops();
      test_backpressure();
      test_seq_wrap();
      test_rst_in_pay();
      test_drop_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/order_dispatcher.md
ORDER_DISPATCHER -- requirements
Module: order_dispatcher

Interface
REQ-001 SHALL take parameter FIFO_DEPTH, default 4, order queue depth in entries (power of two, min 2).
REQ-002 SHALL take parameter MAX_POS, default 15, maximum units held per stock (fits 4 bits).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 buy_signal  in  1  buy request from strategy block, sampled every cycle.
REQ-006 sell_signal  in  1  sell request, sampled every cycle.
REQ-007 stock_id  in  2  stock the request applies to.
REQ-008 price  in  6  price attached to the request.
REQ-009 tx_data  out  8  order byte to the exchange link.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  link accepts byte when tx_valid and tx_ready both high.
REQ-012 pos_sel  in  2  stock selector for position readout.
REQ-013 pos_out  out  4  combinational position of stock pos_sel.
REQ-014 drop_cnt  out  8  rejected requests, saturating at 255.
REQ-015 busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-016 Buy and sell both high in a cycle SHALL be a conflict: no push, no position change, drop_cnt +1.
REQ-017 Buy SHALL be accepted only if position[stock_id] < MAX_POS and FIFO not full; on acceptance position +1 and entry {side=0, stock_id, price} pushed.
REQ-018 Sell SHALL be accepted only if position[stock_id] > 0 and FIFO not full; on acceptance position -1 and entry {side=1, stock_id, price} pushed.
REQ-019 Any non-accepted single buy or sell SHALL increment drop_cnt; drop_cnt holds at 255.
REQ-020 Fullness SHALL use the count registered at start of cycle; a pop in the same cycle does not free space for that cycle's request.
REQ-021 Push and pop in the same cycle (FIFO not full) SHALL both occur; count unchanged.
REQ-022 FSM states SHALL be IDLE, HDR, PAY (plus CHK per REQ-033).
REQ-023 IDLE: if FIFO non-empty, pop head, register header byte into tx_data, go HDR; else stay.
REQ-024 Header byte SHALL be {2'b10, side, stock_id[1:0], seq[2:0]}; payload byte {2'b00, price[5:0]}.
REQ-025 HDR/PAY SHALL hold tx_valid=1 and tx_data stable until tx_ready; on handshake HDR loads payload and goes PAY.
REQ-026 PAY handshake SHALL increment seq (3-bit, wraps 7 to 0) and go IDLE, tx_valid low at least one cycle between orders.
REQ-027 Latency: request accepted in cycle N with FIFO empty and FSM IDLE SHALL give tx_valid=1 with header in cycle N+2.
REQ-028 tx_valid SHALL be low in IDLE; tx_data in IDLE SHALL be 8'h00.
REQ-029 Position SHALL be updated at acceptance, not at transmission, so queued orders count against limits.

Reset
REQ-030 rst SHALL clear FIFO, pointers and count, all positions to 0, seq to 0, drop_cnt to 0, state to IDLE, tx_valid 0, tx_data 8'h00.
REQ-031 rst during HDR/PAY SHALL abandon the order in progress with no further byte; input requests in a reset cycle SHALL be ignored.

Configuration
REQ-032 Macro ORDER_CHECKSUM_EN SHALL select checksum framing.
REQ-033 With ORDER_CHECKSUM_EN defined: PAY handshake goes CHK; CHK sends header XOR payload, seq increments and IDLE entered on CHK handshake.
REQ-034 Without ORDER_CHECKSUM_EN: no CHK state, two-byte orders per REQ-026.

Verification
REQ-035 Reset, buy stock 1 price 6'd20 with tx_ready=1 -> cycle +2 tx_data 8'h88, next 8'h14, pos_out(1)=1, seq 1.
REQ-036 Sell stock 2 with position 0 -> no tx_valid, drop_cnt=1; buy+sell same cycle -> drop_cnt=2.
REQ-037 tx_ready=0, six consecutive buys stock 0 -> four queued, drop_cnt=2, pos_out(0)=4, tx_data held stable.
REQ-038 Sixteen buys stock 3 drained -> pos_out(3)=15, 16th dropped; ninth order header seq wraps to 3'd0.
REQ-039 rst asserted in PAY with tx_ready=0 -> next cycle tx_valid=0, busy=0, all positions 0.
REQ-040 ORDER_CHECKSUM_EN: buy stock 1 price 20 -> bytes 8'h88, 8'h14, 8'h9C.
